// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the adder arbiter and its round-robin picker.
package adder_arbiter_pkg;

    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int DATA_W = 32;

    // Value driven on add_refresh to flush every adder stage at once.
    localparam logic [3:0] REFRESH_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/adder_arbiter_rr_pick4.sv
// Combinational round-robin priority encoder: the first set request at or
// after ptr (wrapping mod 4) wins. index is only meaningful when |req.
module rr_pick4
    import adder_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] index
);

    logic [ID_W-1:0] cand;
    logic            found;

    // Scan requesters starting at ptr; the 2-bit candidate wraps naturally.
    always_comb begin
        grant = '0;
        index = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + ID_W'(k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Arbitrates four requesters onto one 4-stage pipelined adder, keeping at
// most one operation in flight and returning results on a shared bus.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Request side: req_ready is combinational, one-hot, and only ever set for a
// requester whose req_valid is high while the FSM is IDLE. Response side:
// once resp_valid rises, the payload is frozen until resp_valid && resp_ready.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_cin,
    output logic [NREQ-1:0]        req_ready,
    output logic                   resp_valid,
    output logic [ID_W-1:0]        resp_id,
    output logic [DATA_W-1:0]      resp_sum,
    output logic                   resp_cout,
    output logic                   resp_err,
    input  logic                   resp_ready,
    input  logic                   flush,
    output logic                   add_validin,
    output logic [DATA_W-1:0]      add_a,
    output logic [DATA_W-1:0]      add_b,
    output logic                   add_cin,
    output logic                   add_out_allow,
    output logic [4:1]             add_suspend,
    output logic [4:1]             add_refresh,
    input  logic                   add_validout,
    input  logic [DATA_W-1:0]      add_sum,
    input  logic                   add_cout,
    output logic [1:0]             dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              op_cin_q, op_cin_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_sum_q, resp_sum_d;
    logic              resp_cout_q, resp_cout_d;
    logic              resp_err_q, resp_err_d;

    logic [NREQ-1:0]   pick_grant;
    logic [ID_W-1:0]   pick_idx;

    rr_pick4 u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .index (pick_idx)
    );

    // Next-state and output decode; operands stay in op_*_q from ISSUE until
    // WAIT is left, so the adder sees constant inputs at every stage.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_cin_d      = op_cin_q;
        id_d          = id_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_sum_d    = resp_sum_q;
        resp_cout_d   = resp_cout_q;
        resp_err_d    = resp_err_q;
        req_ready     = '0;
        add_validin   = 1'b0;
        add_out_allow = 1'b0;
        add_refresh   = '0;

        case (state_q)
            ST_IDLE: begin
                // rst_n gating keeps req_ready low while reset is held.
                if (rst_n && (|req_valid)) begin
                    req_ready = pick_grant;
                    op_a_d    = req_a[DATA_W*pick_idx +: DATA_W];
                    op_b_d    = req_b[DATA_W*pick_idx +: DATA_W];
                    op_cin_d  = req_cin[pick_idx];
                    id_d      = pick_idx;
                    ptr_d     = pick_idx + 2'd1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (flush) begin
                    // Do not launch an operation that is being aborted.
                    add_refresh = REFRESH_ALL;
                    state_d     = ST_IDLE;
                end else begin
                    add_validin = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                add_out_allow = 1'b1;
                cnt_d         = cnt_q + 1'b1;
                if (flush) begin
                    // Flush beats a result arriving in the same cycle.
                    add_refresh = REFRESH_ALL;
                    state_d     = ST_IDLE;
                end else if (add_validout) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_sum_d   = add_sum;
                    resp_cout_d  = add_cout;
                    resp_err_d   = 1'b0;
                    state_d      = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th WAIT cycle with no result.
                    add_refresh  = REFRESH_ALL;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_sum_d   = '0;
                    resp_cout_d  = 1'b0;
                    resp_err_d   = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                // Grant only from IDLE, so the earliest next grant is the
                // cycle after this handshake.
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_cin_q     <= 1'b0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_cin_q     <= op_cin_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
            resp_cout_q  <= resp_cout_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_sum    = resp_sum_q;
    assign resp_cout   = resp_cout_q;
    assign resp_err    = resp_err_q;
    assign add_a       = op_a_q;
    assign add_b       = op_b_q;
    assign add_cin     = op_cin_q;
    assign add_suspend = '0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a 4-stage adder model and a
// scoreboard of expected responses.
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_cin;
  logic [3:0]   req_ready;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic [31:0]  resp_sum;
  logic         resp_cout, resp_err;
  logic         resp_ready, flush;
  logic         add_validin;
  logic [31:0]  add_a, add_b;
  logic         add_cin, add_out_allow;
  logic [4:1]   add_suspend, add_refresh;
  logic         add_validout;
  logic [31:0]  add_sum;
  logic         add_cout;
  logic [1:0]   dbg_state;

  adder_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
    .resp_cout(resp_cout), .resp_err(resp_err), .resp_ready(resp_ready),
    .flush(flush),
    .add_validin(add_validin), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_out_allow(add_out_allow), .add_suspend(add_suspend),
    .add_refresh(add_refresh),
    .add_validout(add_validout), .add_sum(add_sum), .add_cout(add_cout),
    .dbg_state(dbg_state)
  );

  // ---------------- 4-stage adder model ----------------
  logic [3:0] pipe;
  logic       never_mode;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else if (add_refresh != 4'h0) pipe <= '0;
    else pipe <= {pipe[2:0], add_validin};
  end
  assign add_validout = pipe[3] && !never_mode;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  // ---------------- scoreboard ----------------
  // Entry layout: {id[1:0], cout, sum[31:0], err}
  logic [35:0] exp_q[$];
  int          grant_q[$];
  int          grant_cyc;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [31:0] op_a[4];
  logic [31:0] op_b[4];
  logic        op_cin[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [35:0] mk_exp(input int i);
    logic [32:0] s;
    s = {1'b0, op_a[i]} + {1'b0, op_b[i]} + {32'd0, op_cin[i]};
    return {2'(i), s, 1'b0};
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pack_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
      req_cin[i]        = op_cin[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      op_a[i]   = $urandom();
      op_b[i]   = $urandom();
      op_cin[i] = 1'($urandom_range(0, 1));
    end
    pack_ops();
  endtask

  task automatic apply_reset();
    tick();
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pop_compare(input bit chk_lat);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      check("resp_without_expected", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("resp_id", resp_id, e[35:34]);
      check("resp_cout", resp_cout, e[33]);
      check("resp_sum", resp_sum, e[32:1]);
      check("resp_err", resp_err, e[0]);
      if (chk_lat) check("latency", cyc - grant_cyc, 6);
    end
  endtask

  // Caller has just ticked and driven inputs; samples each cycle, records
  // grants, and scores handshaked responses until want responses arrive.
  task automatic run_cycles(input int max_cyc, input int want, input bit chk_lat);
    int got = 0;
    int n = 0;
    while (1) begin
      settle();
      if (req_ready != 4'h0) begin
        check("grant_onehot", $countones(req_ready), 1);
        grant_q.push_back(onehot_idx(req_ready));
        exp_q.push_back(mk_exp(onehot_idx(req_ready)));
        grant_cyc = cyc;
      end
      if (resp_valid && resp_ready) begin
        pop_compare(chk_lat);
        got++;
      end
      if (got >= want || n >= max_cyc) break;
      n++;
      tick();
    end
    if (got < want) check("resp_count_timeout", got, want);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [34:0] snap;
    int          n;
    int          w;
    int          seen;

    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    resp_ready = 1'b0; flush = 1'b0; never_mode = 1'b0;
    #1 rst_n = 1'b0;

    // Reset values, with a request pending to prove req_ready stays low.
    tick();
    req_valid = 4'b0001;
    settle();
    check("rst_req_ready", req_ready, 4'h0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_sum", resp_sum, 0);
    check("rst_resp_cout", resp_cout, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_add_validin", add_validin, 0);
    check("rst_add_ab", {add_a, add_b}, 64'h0);
    check("rst_add_cin", add_cin, 0);
    check("rst_out_allow", add_out_allow, 0);
    check("rst_refresh", add_refresh, 4'h0);
    check("rst_suspend", add_suspend, 4'h0);
    check("rst_state", dbg_state, ST_IDLE);
    req_valid = '0;
    tick();
    rst_n = 1'b1;

    // Carry-out case on requester 0.
    rand_ops();
    op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'h1; op_cin[0] = 1'b0;
    pack_ops();
    tick();
    req_valid = 4'b0001;
    settle();
    check("s1_ready", req_ready, 4'b0001);
    exp_q.push_back(mk_exp(0));
    grant_cyc = cyc;
    tick();
    req_valid = '0;
    settle();
    check("s1_validin", add_validin, 1);
    check("s1_add_a", add_a, 32'hFFFF_FFFF);
    check("s1_state_issue", dbg_state, ST_ISSUE);
    tick();
    resp_ready = 1'b1;
    run_cycles(30, 1, 1);

    // All four requesting from ptr=0: order 0,1,2,3,0.
    apply_reset();
    rand_ops();
    grant_q.delete();
    tick();
    req_valid = 4'hF;
    resp_ready = 1'b1;
    run_cycles(80, 5, 1);
    tick();
    req_valid = '0;
    check("s2_grant_count", grant_q.size(), 5);
    for (int i = 0; i < 5 && i < grant_q.size(); i++)
      check("s2_grant_order", grant_q[i], i % 4);

    // Back-pressure: response held 10 cycles, then grant the cycle after.
    rand_ops();
    tick();
    req_valid = 4'b0100;
    resp_ready = 1'b0;
    settle();
    check("s3_ready", req_ready, 4'b0100);
    exp_q.push_back(mk_exp(2));
    grant_cyc = cyc;
    tick();
    req_valid = 4'b1000;
    settle();
    n = 0;
    while (!resp_valid && n < 20) begin
      tick(); settle(); n++;
    end
    check("s3_resp_seen", resp_valid, 1);
    check("s3_latency", cyc - grant_cyc, 6);
    snap = {resp_id, resp_cout, resp_sum};
    for (int k = 0; k < 10; k++) begin
      tick();
      flush = (k == 5);
      settle();
      check("s3_payload_stable", {resp_id, resp_cout, resp_sum}, snap);
      check("s3_err_stable", resp_err, 0);
      check("s3_valid_held", resp_valid, 1);
      check("s3_no_ready", req_ready, 4'h0);
      check("s3_no_refresh", add_refresh, 4'h0);
    end
    tick();
    flush = 1'b0;
    resp_ready = 1'b1;
    settle();
    check("s3_no_grant_on_hs", req_ready, 4'h0);
    pop_compare(0);
    tick();
    resp_ready = 1'b0;
    settle();
    check("s3_next_grant", req_ready, 4'b1000);
    exp_q.push_back(mk_exp(3));
    grant_cyc = cyc;
    tick();
    req_valid = '0;
    resp_ready = 1'b1;
    run_cycles(30, 1, 1);

    // Timeout: the adder never answers.
    tick();
    never_mode = 1'b1;
    resp_ready = 1'b0;
    req_valid = 4'b1000;
    settle();
    check("s4_ready", req_ready, 4'b1000);
    exp_q.push_back({2'd3, 33'd0, 1'b1});
    tick();
    req_valid = '0;
    settle();
    n = 0; w = 0;
    while (1) begin
      if (add_out_allow) w++;
      if (add_refresh != 4'h0 || n >= 40) break;
      tick(); settle(); n++;
    end
    check("s4_wait_cycles", w, 15);
    check("s4_refresh", add_refresh, 4'hF);
    check("s4_no_resp_yet", resp_valid, 0);
    tick();
    settle();
    check("s4_refresh_one_cycle", add_refresh, 4'h0);
    check("s4_resp_valid", resp_valid, 1);
    check("s4_resp_err", resp_err, 1);
    tick();
    resp_ready = 1'b1;
    run_cycles(10, 1, 0);

    // Flush in the second WAIT cycle.
    tick();
    never_mode = 1'b0;
    resp_ready = 1'b0;
    req_valid = 4'b0001;
    settle();
    check("s5_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    settle();
    check("s5_issue", dbg_state, ST_ISSUE);
    tick();
    settle();
    check("s5_wait1", dbg_state, ST_WAIT);
    tick();
    flush = 1'b1;
    settle();
    check("s5_refresh", add_refresh, 4'hF);
    tick();
    flush = 1'b0;
    settle();
    check("s5_refresh_off", add_refresh, 4'h0);
    check("s5_idle", dbg_state, ST_IDLE);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (resp_valid) seen++;
      tick(); settle();
    end
    check("s5_no_resp", seen, 0);
    tick();
    req_valid = 4'b0011;
    settle();
    check("s5_next_grant", req_ready, 4'b0010);
    exp_q.push_back(mk_exp(1));
    grant_cyc = cyc;
    tick();
    req_valid = '0;
    resp_ready = 1'b1;
    run_cycles(30, 1, 1);

    // Asynchronous reset during WAIT.
    tick();
    resp_ready = 1'b0;
    req_valid = 4'b0100;
    settle();
    check("s6_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();
    settle();
    check("s6_in_wait", dbg_state, ST_WAIT);
    #2 rst_n = 1'b0;
    #1;
    check("s6_state", dbg_state, ST_IDLE);
    check("s6_out_allow", add_out_allow, 0);
    check("s6_validin", add_validin, 0);
    check("s6_add_ab", {add_a, add_b}, 64'h0);
    check("s6_cin", add_cin, 0);
    check("s6_resp", {resp_valid, resp_id, resp_sum, resp_cout, resp_err}, 0);
    check("s6_refresh", add_refresh, 4'h0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick(); settle();
      if (resp_valid) seen++;
    end
    check("s6_no_resp", seen, 0);

    check("exp_q_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: the number of WAIT cycles without add_validout before the block aborts the operation.
REQ-002 clk  in  1  single clock; all state is updated on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  4  per-requester request valid.
REQ-005 req_a, req_b  in  128 each  packed 32-bit operands; requester i uses bits [32i+31:32i].
REQ-006 req_cin  in  4  per-requester carry-in.
REQ-007 req_ready  out  4  one-hot grant; a request is accepted when req_valid[i] && req_ready[i].
REQ-008 resp_valid, resp_id[1:0], resp_sum[31:0], resp_cout, resp_err  out  shared response bus.
REQ-009 resp_ready  in  1  response consumer accept.
REQ-010 flush  in  1  abort the in-flight operation.
REQ-011 add_validin, add_a[31:0], add_b[31:0], add_cin, add_out_allow, add_suspend[4:1], add_refresh[4:1]  out  drive the 4-stage pipelined adder.
REQ-012 add_validout, add_sum[31:0], add_cout  in  adder result.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-014 Operand hold: the adder samples add_a/add_b byte slices at every stage, so add_a, add_b and add_cin SHALL stay constant from ISSUE until leaving WAIT, and at most one operation SHALL be in flight.
REQ-015 In IDLE, when any req_valid is set, the arbiter SHALL grant round-robin starting from ptr, assert req_ready for exactly one cycle on the winner, latch the winner's operands and id, and go to ISSUE.
REQ-016 ptr SHALL advance to the granted index + 1 (mod 4) on each grant.
REQ-017 In ISSUE, add_validin SHALL be 1 for exactly one cycle, then the FSM goes to WAIT.
REQ-018 In WAIT, add_validin SHALL be 0, add_out_allow SHALL be 1, and a wait counter SHALL increment each cycle.
REQ-019 When add_validout=1 in WAIT, the block SHALL capture add_sum/add_cout into the resp registers, set resp_err=0, and go to RESP.
REQ-020 The nominal latency from the grant cycle to resp_valid SHALL be 6 cycles (ISSUE 1 + adder 4 + capture 1).
REQ-021 On timeout, when the wait counter reaches TIMEOUT without add_validout, the block SHALL pulse add_refresh=4'hF for one cycle, set resp_sum=0, resp_cout=0, resp_err=1, and go to RESP.
REQ-022 In RESP, resp_valid=1 and the payload SHALL be held stable until resp_ready=1; on that handshake the FSM returns to IDLE.
REQ-023 A new grant SHALL NOT be issued in the same cycle as the RESP handshake; the earliest next grant is the following cycle.
REQ-024 flush=1 in ISSUE or WAIT SHALL pulse add_refresh=4'hF and return the FSM to IDLE with no response and no ptr change beyond the grant already made.
REQ-025 flush in IDLE or RESP SHALL be ignored.
REQ-026 If add_validout and flush occur in the same cycle, flush SHALL win and the result is dropped.
REQ-027 add_suspend SHALL be tied to 4'b0000.
REQ-028 add_refresh SHALL be 4'b0000 except during the abort pulses defined in REQ-021 and REQ-024.
REQ-029 Carry arithmetic belongs to the adder; the block itself performs no arithmetic beyond the counter and ptr.

Reset
REQ-030 While rst_n=0, the block SHALL set state=IDLE, ptr=0, wait counter=0, req_ready=0, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, resp_err=0, add_validin=0, add_a/add_b/add_cin=0, add_out_allow=0, add_refresh=0.
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no response; the adder receives its own reset separately.

Structure
REQ-032 A shared package SHALL hold the state enum, NREQ=4, the ID width (2) and the 4'hF refresh-all constant.
REQ-033 A combinational round-robin priority encoder SHALL be a sub-module named rr_pick4 (inputs: req[3:0], ptr[1:0]; outputs: one-hot grant, index).

Verification
REQ-034 req_valid=4'b0001 with a=32'hFFFFFFFF, b=1, cin=0 -> req_ready=0001, then 6 cycles later resp_valid with resp_id=0, sum=0, cout=1, err=0.
REQ-035 All four req_valid held high with ptr=0 -> grants in order 0,1,2,3,0; each response carries the matching id and a+b.
REQ-036 resp_ready held low for 10 cycles in RESP -> the payload stays stable, no new req_ready occurs, and the next grant comes one cycle after the handshake.
REQ-037 Adder model never returns add_validout -> after 15 WAIT cycles, add_refresh=4'hF for 1 cycle, then resp_err=1, sum=0.
REQ-038 flush asserted in the 2nd WAIT cycle -> add_refresh=4'hF for 1 cycle, no resp_valid, FSM in IDLE, and the next request is granted normally.
REQ-039 rst_n pulsed low asynchronously during WAIT -> all outputs take their REQ-030 values immediately, and no response follows.
